clint: RTL and testbench

Core-local interruptor: the machine timer and software-interrupt source that drives the pending-interrupt inputs of the machine-mode CSR/trap unit. It holds a free-running 64-bit `mtime`, a 64-bit `mtimecmp` and a 1-bit `msip`, all memory-mapped behind a single-outstanding 32-bit request/response port. It presents level-sensitive `mtip_o`/`msip_o` to the core, which latches them into `mip` and raises the trap.

---
 rtl/clint.sv | 132 +++++++++++++
 tb/tb_clint.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clint.sv
// Core-local interruptor: free-running 64-bit mtime with prescaler, mtimecmp and msip
// behind a single-outstanding 32-bit request/response port; drives mtip_o/msip_o.
module clint #(
    parameter int unsigned TickDiv = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [15:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_wstrb_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        mtip_o,
    output logic        msip_o
);
    localparam int unsigned PW = (TickDiv > 1) ? $clog2(TickDiv) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TickDiv - 1);

    localparam logic [13:0] W_MSIP  = 14'h0000;
    localparam logic [13:0] W_CMPLO = 14'h1000;
    localparam logic [13:0] W_CMPHI = 14'h1001;
    localparam logic [13:0] W_MTLO  = 14'h2FFE;
    localparam logic [13:0] W_MTHI  = 14'h2FFF;

    typedef enum logic {IDLE, RESP} state_e;

    state_e        state_q, state_d;
    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic          msip_q, msip_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [13:0]   widx;
    logic          addr_lsb_unused;
    logic          accept;
    logic          wr;
    logic          tick;
    logic [31:0]   rd_word;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = st[b] ? wd[b*8 +: 8] : old[b*8 +: 8];
        end
        return res;
    endfunction

    assign widx            = req_addr_i[15:2];
    assign addr_lsb_unused = ^req_addr_i[1:0];
    assign accept          = (state_q == IDLE) && req_valid_i;
    assign wr              = accept && req_we_i;
    assign tick            = (presc_q == PMAX);

    always_comb begin
        rd_word = '0;
        case (widx)
            W_MSIP:  rd_word = {31'b0, msip_q};
            W_CMPLO: rd_word = mtimecmp_q[31:0];
            W_CMPHI: rd_word = mtimecmp_q[63:32];
            W_MTLO:  rd_word = mtime_q[31:0];
            W_MTHI:  rd_word = mtime_q[63:32];
            default: rd_word = '0;
        endcase
    end

    // Handshake: one outstanding request, response held until consumed.
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    state_d = RESP;
                    rdata_d = req_we_i ? 32'h0 : rd_word;
                end
            end
            RESP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Register updates; an mtime write overrides that cycle's increment.
    always_comb begin
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        presc_d    = tick ? '0 : presc_q + 1'b1;
        if (wr) begin
            case (widx)
                W_MSIP:  if (req_wstrb_i[0]) msip_d = req_wdata_i[0];
                W_CMPLO: mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0], req_wdata_i, req_wstrb_i);
                W_CMPHI: mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], req_wdata_i, req_wstrb_i);
                W_MTLO:  mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], req_wdata_i, req_wstrb_i)};
                W_MTHI:  mtime_d = {merge(mtime_q[63:32], req_wdata_i, req_wstrb_i), mtime_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
            presc_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            presc_q    <= presc_d;
            rdata_q    <= rdata_d;
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_rdata_o = rdata_q;
    assign mtip_o      = (mtime_q >= mtimecmp_q);
    assign msip_o      = msip_q;

endmodule

// File: tb/tb_clint.sv
// Bench for clint: directed table, hand-written corner sequences and random traffic,
// all checked every cycle against a cycle-count based reference model.
module tb_clint;
    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        mtip;
    logic        msip;

    int total = 0;
    int bad   = 0;

    clint #(.TickDiv(TD)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .mtip_o(mtip), .msip_o(msip)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: mtime advances on every TD-th cycle since reset, writes win.
    logic [63:0] m_mtime, m_cmp;
    logic        m_msip, m_busy;
    logic [31:0] m_rdata;
    int          m_cyc;

    function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] w, input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = s[b] ? w[b*8 +: 8] : o[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [15:0] a);
        case (a & 16'hFFFC)
            16'h0000: return {31'b0, m_msip};
            16'h4000: return m_cmp[31:0];
            16'h4004: return m_cmp[63:32];
            16'hBFF8: return m_mtime[31:0];
            16'hBFFC: return m_mtime[63:32];
            default:  return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        logic written;
        if (!rst_n) begin
            m_mtime = 64'h0; m_cmp = '1; m_msip = 1'b0;
            m_busy = 1'b0; m_rdata = 32'h0; m_cyc = 0;
        end else begin
            written = 1'b0;
            if (m_busy) begin
                if (rsp_ready) m_busy = 1'b0;
            end else if (req_valid) begin
                m_busy  = 1'b1;
                m_rdata = req_we ? 32'h0 : m_read(req_addr);
                if (req_we) begin
                    case (req_addr & 16'hFFFC)
                        16'h0000: if (req_wstrb[0]) m_msip = req_wdata[0];
                        16'h4000: m_cmp[31:0]  = mrg(m_cmp[31:0], req_wdata, req_wstrb);
                        16'h4004: m_cmp[63:32] = mrg(m_cmp[63:32], req_wdata, req_wstrb);
                        16'hBFF8: begin m_mtime[31:0]  = mrg(m_mtime[31:0], req_wdata, req_wstrb); written = 1'b1; end
                        16'hBFFC: begin m_mtime[63:32] = mrg(m_mtime[63:32], req_wdata, req_wstrb); written = 1'b1; end
                        default: ;
                    endcase
                end
            end
            if (!written && (m_cyc % TD == TD - 1)) m_mtime = m_mtime + 64'd1;
            m_cyc++;
        end
    end

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("req_ready", req_ready, !m_busy);
            chk("rsp_valid", rsp_valid, m_busy);
            if (m_busy) chk("rsp_rdata", rsp_rdata, m_rdata);
            chk("mtip", mtip, m_mtime >= m_cmp);
            chk("msip", msip, m_msip);
        end
    end

    task automatic bus(input logic we, input logic [15:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input int hold,
                       output logic [31:0] rd, output logic tip, output logic sip);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_wstrb = st;
        rsp_ready = (hold == 0);
        @(negedge clk);
        req_valid = 1'b0;
        rd = rsp_rdata; tip = mtip; sip = msip;
        for (int i = 0; i < hold; i++) @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rd;
        logic        exp_sip;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic [31:0] rd;
        logic tip, sip;
        int n;
        logic [15:0] addrs[5];
        addrs = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC};

        tbl[0]  = '{1'b0, 16'hBFFC, 32'h0,         4'h0, 32'h0,         1'b0};
        tbl[1]  = '{1'b0, 16'h4000, 32'h0,         4'h0, 32'hFFFF_FFFF, 1'b0};
        tbl[2]  = '{1'b0, 16'h4004, 32'h0,         4'h0, 32'hFFFF_FFFF, 1'b0};
        tbl[3]  = '{1'b0, 16'h0000, 32'h0,         4'h0, 32'h0,         1'b0};
        tbl[4]  = '{1'b1, 16'h0000, 32'hFFFF_FFFF, 4'b0010, 32'h0,      1'b0};
        tbl[5]  = '{1'b0, 16'h0000, 32'h0,         4'h0, 32'h0,         1'b0};
        tbl[6]  = '{1'b1, 16'h0000, 32'hFFFF_FFFF, 4'b0001, 32'h0,      1'b1};
        tbl[7]  = '{1'b0, 16'h0000, 32'h0,         4'h0, 32'h1,         1'b1};
        tbl[8]  = '{1'b0, 16'h0003, 32'h0,         4'h0, 32'h1,         1'b1};
        tbl[9]  = '{1'b1, 16'h4004, 32'h1234_5678, 4'b0101, 32'h0,      1'b1};
        tbl[10] = '{1'b0, 16'h4004, 32'h0,         4'h0, 32'hFF34_FF78, 1'b1};
        tbl[11] = '{1'b1, 16'h1234, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b1};
        tbl[12] = '{1'b0, 16'h1234, 32'h0,         4'h0, 32'h0,         1'b1};
        tbl[13] = '{1'b1, 16'h0000, 32'h0,         4'b0001, 32'h0,      1'b0};

        // Reset and prescaler
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_mtip", mtip, 0);
        chk("rst_msip", msip, 0);
        repeat (40) @(negedge clk);
        bus(1'b0, 16'hBFF8, 32'h0, 4'h0, 0, rd, tip, sip);
        chk("presc_mtime_10pm1", (rd >= 9 && rd <= 11), 1);

        foreach (tbl[i]) begin
            bus(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, 0, rd, tip, sip);
            chk($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_msip", i), sip, tbl[i].exp_sip);
        end

        // Timer interrupt
        bus(1'b1, 16'hBFFC, 32'h0, 4'hF, 0, rd, tip, sip);
        bus(1'b1, 16'hBFF8, 32'h0, 4'hF, 0, rd, tip, sip);
        bus(1'b1, 16'h4004, 32'h0, 4'hF, 0, rd, tip, sip);
        bus(1'b1, 16'h4000, 32'd50, 4'hF, 0, rd, tip, sip);
        chk("tip_low_after_cmp", tip, 0);
        n = 0;
        while (!mtip && n < 400) begin @(negedge clk); n++; end
        chk("tip_rise_seen", n < 400, 1);
        chk("tip_rise_at_50", m_mtime, 64'd50);
        bus(1'b1, 16'h4004, 32'h1, 4'hF, 0, rd, tip, sip);
        chk("tip_clear_on_rsp", tip, 0);

        // Carry into the high word
        bus(1'b1, 16'hBFFC, 32'h7, 4'hF, 0, rd, tip, sip);
        bus(1'b1, 16'hBFF8, 32'hFFFF_FFFE, 4'hF, 0, rd, tip, sip);
        repeat (8) @(negedge clk);
        bus(1'b0, 16'hBFF8, 32'h0, 4'h0, 0, rd, tip, sip);
        chk("carry_lo", rd <= 1, 1);
        bus(1'b0, 16'hBFFC, 32'h0, 4'h0, 0, rd, tip, sip);
        chk("carry_hi", rd, 32'h8);

        // mtime write on a tick cycle wins over the increment
        n = 0;
        do begin @(negedge clk); n++; end while (m_cyc % TD != TD - 2 && n < 2 * TD);
        bus(1'b1, 16'hBFF8, 32'h0000_1000, 4'hF, 0, rd, tip, sip);
        bus(1'b0, 16'hBFF8, 32'h0, 4'h0, 0, rd, tip, sip);
        chk("tick_write_prio", rd, 32'h0000_1000);

        // Backpressure on an unmapped read, then reset during the wait
        bus(1'b1, 16'h0000, 32'h1, 4'h1, 0, rd, tip, sip);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h1234; rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_rdata", rsp_rdata, 0);
            chk("bp_req_ready", req_ready, 0);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_rsp_valid", rsp_valid, 0);
        chk("rst_mid_req_ready", req_ready, 1);
        chk("rst_mid_msip", msip, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        bus(1'b0, 16'h4004, 32'h0, 4'h0, 0, rd, tip, sip);
        chk("rst_mid_cmp_hi", rd, 32'hFFFF_FFFF);

        // Random traffic against the model
        for (int t = 0; t < 300; t++) begin
            logic        we;
            logic [15:0] a;
            logic [31:0] wd;
            we = $urandom_range(0, 1);
            if ($urandom_range(0, 5) == 0) a = 16'($urandom);
            else a = addrs[$urandom_range(0, 4)] | 16'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: wd = $urandom;
                1: wd = 32'hFFFF_FFF0 + $urandom_range(0, 15);
                default: wd = $urandom_range(0, 300);
            endcase
            if ((a & 16'hFFFC) == 16'h4004 || (a & 16'hFFFC) == 16'hBFFC)
                if ($urandom_range(0, 3) != 0) wd = $urandom_range(0, 1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            bus(we, a, wd, 4'($urandom), $urandom_range(0, 3), rd, tip, sip);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
